nbody_host_driver: RTL and testbench

- Avalon-MM style initiator that drives the nbody accelerator's register/memory slave port from on-chip logic instead of the HPS.
- Configures the accelerator: body count and gap. Streams in body state (x, y, m, vx, vy). Raises GO, polls DONE and reads back positions.
- Runs the DONE/READ handshake for a requested number of frames.
- Sits between a body-data source stream and a result sink stream, e.g. a scenario ROM feeding a display pipeline.

---
 rtl/nbody_host_driver_if.sv | 18 +
 rtl/nbody_host_driver.sv | 361 ++++++++++++++++++++++++++++++++++++
 tb/tb_nbody_host_driver.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nbody_host_driver_if.sv
// Avalon-MM style register/memory bus between the nbody host driver (master)
// and the accelerator slave port.
interface nbody_host_driver_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] m_addr;
  logic                  m_write;
  logic                  m_read;
  logic                  m_chipselect;
  logic [DATA_WIDTH-1:0] m_writedata;
  logic [DATA_WIDTH-1:0] m_readdata;

  modport master (output m_addr, m_write, m_read, m_chipselect, m_writedata,
                  input  m_readdata);
  modport slave  (input  m_addr, m_write, m_read, m_chipselect, m_writedata,
                  output m_readdata);
endinterface

// File: rtl/nbody_host_driver.sv
// On-chip initiator that configures, loads, runs and reads back the nbody accelerator.
// Optional DONE-poll timeout is enabled by defining NBODY_DRV_TIMEOUT_EN.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | waiting for start
// CFG_N       | write N_BODIES
// CFG_GAP     | write GAP
// LOAD        | accept body words, one write per word (x, y, m, vx, vy)
// GO          | write GO=1
// POLL_WAIT   | idle POLL_INTERVAL cycles between DONE polls
// POLL_RD     | read DONE, branch on bit 0
// RD_X / RD_Y | read back position of body idx
// EMIT        | present result on output stream until accepted
// ACK_SET     | write READ=1, one frame consumed
// ACK_CLR     | write READ=0, back to polling
// STOP        | write GO=0
// FINISH      | pulse run_done, drop busy
module nbody_host_driver #(
  parameter int BODIES          = 512,
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 16,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int RD_LATENCY      = 1,
  parameter int POLL_INTERVAL   = 16,
  parameter int TIMEOUT_CYCLES  = 2**24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [BODY_ADDR_WIDTH-1:0] n_bodies,
  input  logic [BODY_ADDR_WIDTH-1:0] gap,
  input  logic [15:0]                n_frames,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_x,
  output logic [DATA_WIDTH-1:0]      out_y,
  output logic [BODY_ADDR_WIDTH-1:0] out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic                       run_done,
  output logic                       err,
  nbody_host_driver_if.master        bus
);
  localparam int BAW = BODY_ADDR_WIDTH;
  localparam logic [BAW-1:0] ONE_B  = BAW'(1);
  localparam logic [BAW-1:0] ZERO_B = '0;

  localparam logic [6:0] OP_GO     = 7'h00;
  localparam logic [6:0] OP_READ   = 7'h01;
  localparam logic [6:0] OP_NBOD   = 7'h02;
  localparam logic [6:0] OP_X      = 7'h03;
  localparam logic [6:0] OP_GAP    = 7'h08;
  localparam logic [6:0] OP_DONE   = 7'h40;
  localparam logic [6:0] OP_RD_X   = 7'h41;
  localparam logic [6:0] OP_RD_Y   = 7'h42;

  localparam logic [31:0] POLL_LOAD = 32'(POLL_INTERVAL - 1);
  localparam logic [31:0] RDL_LOAD  = 32'(RD_LATENCY);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_N, S_CFG_GAP, S_LOAD, S_GO, S_POLL_WAIT, S_POLL_RD,
    S_RD_X, S_RD_Y, S_EMIT, S_ACK_SET, S_ACK_CLR, S_STOP, S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [BAW-1:0]        n_q, n_d, gap_q, gap_d, body_q, body_d, idx_q, idx_d;
  logic [15:0]           frames_q, frames_d;
  logic [2:0]            word_q, word_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0] xcap_q, xcap_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
  logic [BAW-1:0]        out_idx_q, out_idx_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d, run_done_q, run_done_d, err_q, err_d;

`ifdef NBODY_DRV_TIMEOUT_EN
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);
  logic [31:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif
  logic unused_bodies;
  assign unused_bodies = (BODIES == 0);

  function automatic logic [ADDR_WIDTH-1:0] bus_addr(input logic [6:0] op,
                                                     input logic [BAW-1:0] body);
    return ADDR_WIDTH'({op, body});
  endfunction

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    gap_d       = gap_q;
    body_d      = body_q;
    idx_d       = idx_q;
    frames_d    = frames_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    rd_pend_d   = rd_pend_q;
    xcap_d      = xcap_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    run_done_d  = 1'b0;
    err_d       = err_q;
`ifdef NBODY_DRV_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        if (n_bodies != ZERO_B && n_frames != 16'd0) begin
          n_d      = n_bodies;
          gap_d    = gap;
          frames_d = n_frames;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          state_d  = S_CFG_N;
        end else begin
          err_d = 1'b1;
        end
      end
      S_CFG_N: begin
        wr_d    = 1'b1;
        addr_d  = bus_addr(OP_NBOD, ZERO_B);
        wdata_d = DATA_WIDTH'(n_q);
        state_d = S_CFG_GAP;
      end
      S_CFG_GAP: begin
        wr_d       = 1'b1;
        addr_d     = bus_addr(OP_GAP, ZERO_B);
        wdata_d    = DATA_WIDTH'(gap_q);
        body_d     = ZERO_B;
        word_d     = 3'd0;
        in_ready_d = 1'b1;
        state_d    = S_LOAD;
      end
      S_LOAD: if (in_valid && in_ready_q) begin
        wr_d    = 1'b1;
        addr_d  = bus_addr(OP_X + 7'(word_q), body_q);
        wdata_d = in_data;
        if (word_q == 3'd4) begin
          word_d = 3'd0;
          body_d = body_q + ONE_B;
          if (body_q == n_q - ONE_B) begin
            in_ready_d = 1'b0;
            state_d    = S_GO;
          end
        end else begin
          word_d = word_q + 3'd1;
        end
      end
      S_GO: begin
        wr_d    = 1'b1;
        addr_d  = bus_addr(OP_GO, ZERO_B);
        wdata_d = DATA_WIDTH'(1);
        cnt_d   = POLL_LOAD;
`ifdef NBODY_DRV_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        rd_pend_d = 1'b0;
        if (cnt_q == '0) state_d = S_POLL_RD;
        else             cnt_d   = cnt_q - 32'd1;
`ifdef NBODY_DRV_TIMEOUT_EN
        tmo_d = tmo_q + 32'd1;
        if (tmo_q > TMO_LIMIT) begin
          err_d   = 1'b1;
          state_d = S_STOP;
        end
`endif
      end
      S_POLL_RD: begin
`ifdef NBODY_DRV_TIMEOUT_EN
        tmo_d = tmo_q + 32'd1;
`endif
        if (!rd_pend_q) begin
          rd_d      = 1'b1;
          addr_d    = bus_addr(OP_DONE, ZERO_B);
          rd_pend_d = 1'b1;
          cnt_d     = RDL_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          rd_pend_d = 1'b0;
          if (bus.m_readdata[0]) begin
            idx_d   = ZERO_B;
            state_d = S_RD_X;
          end else begin
            cnt_d   = POLL_LOAD;
            state_d = S_POLL_WAIT;
          end
        end
      end
      S_RD_X: begin
        if (!rd_pend_q) begin
          rd_d      = 1'b1;
          addr_d    = bus_addr(OP_RD_X, idx_q);
          rd_pend_d = 1'b1;
          cnt_d     = RDL_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          rd_pend_d = 1'b0;
          xcap_d    = bus.m_readdata;
          state_d   = S_RD_Y;
        end
      end
      S_RD_Y: begin
        if (!rd_pend_q) begin
          rd_d      = 1'b1;
          addr_d    = bus_addr(OP_RD_Y, idx_q);
          rd_pend_d = 1'b1;
          cnt_d     = RDL_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          rd_pend_d   = 1'b0;
          out_valid_d = 1'b1;
          out_x_d     = xcap_q;
          out_y_d     = bus.m_readdata;
          out_idx_d   = idx_q;
          out_last_d  = (idx_q == n_q - ONE_B);
          state_d     = S_EMIT;
        end
      end
      // Bus stays quiet while the sink back-pressures.
      S_EMIT: if (out_ready) begin
        out_valid_d = 1'b0;
        if (out_last_q) begin
          state_d = S_ACK_SET;
        end else begin
          idx_d   = idx_q + ONE_B;
          state_d = S_RD_X;
        end
      end
      S_ACK_SET: begin
        wr_d     = 1'b1;
        addr_d   = bus_addr(OP_READ, ZERO_B);
        wdata_d  = DATA_WIDTH'(1);
        frames_d = frames_q - 16'd1;
        state_d  = (frames_q == 16'd1) ? S_STOP : S_ACK_CLR;
      end
      S_ACK_CLR: begin
        wr_d    = 1'b1;
        addr_d  = bus_addr(OP_READ, ZERO_B);
        wdata_d = '0;
        cnt_d   = POLL_LOAD;
`ifdef NBODY_DRV_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = S_POLL_WAIT;
      end
      S_STOP: begin
        wr_d    = 1'b1;
        addr_d  = bus_addr(OP_GO, ZERO_B);
        wdata_d = '0;
        state_d = S_FINISH;
      end
      S_FINISH: begin
        run_done_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      gap_q       <= '0;
      body_q      <= '0;
      idx_q       <= '0;
      frames_q    <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      xcap_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      run_done_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef NBODY_DRV_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      gap_q       <= gap_d;
      body_q      <= body_d;
      idx_q       <= idx_d;
      frames_q    <= frames_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      rd_pend_q   <= rd_pend_d;
      xcap_q      <= xcap_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      run_done_q  <= run_done_d;
      err_q       <= err_d;
`ifdef NBODY_DRV_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign out_x            = out_x_q;
  assign out_y            = out_y_q;
  assign out_idx          = out_idx_q;
  assign out_last         = out_last_q;
  assign busy             = busy_q;
  assign run_done         = run_done_q;
  assign err              = err_q;
  assign bus.m_addr       = addr_q;
  assign bus.m_write      = wr_q;
  assign bus.m_read       = rd_q;
  assign bus.m_chipselect = wr_q | rd_q;
  assign bus.m_writedata  = wdata_q;
endmodule

// File: tb/tb_nbody_host_driver.sv
// Randomized bench for nbody_host_driver: behavioural accelerator slave, stream
// source/sink, and an expected bus/output transcript built from the opcode rules.
module tb_nbody_host_driver;
  localparam int DW = 64, AW = 16, BAW = 9, RDL = 1, TMO = 100;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic [BAW-1:0]  n_bodies = '0, gap_in = '0;
  logic [15:0]     n_frames = '0;
  logic            in_valid = 1'b0, in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            out_valid, out_ready = 1'b0;
  logic [DW-1:0]   out_x, out_y;
  logic [BAW-1:0]  out_idx;
  logic            out_last, busy, run_done, err;

  nbody_host_driver_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  nbody_host_driver #(.BODIES(512), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                      .RD_LATENCY(RDL), .POLL_INTERVAL(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_bodies(n_bodies), .gap(gap_in),
    .n_frames(n_frames), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .run_done(run_done),
    .err(err), .bus(bus));

  typedef struct packed {
    logic          w;
    logic          r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } acc_t;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] ad(input int op, input int b);
    return AW'((op << 9) | b);
  endfunction

  // environment state shared by driver/monitor and test sequence
  logic [DW-1:0] src_q[$];
  acc_t          bus_log[$];
  logic [DW-1:0] ox[$], oy[$];
  logic [9:0]    oil[$];
  logic [DW-1:0] xm[512], ym[512];
  int in_gap_pct = 0, ordy_pct = 100, stall_cnt = 0, done_on = 1;
  bit stall_req = 0;
  int polls = 0, acked = 0, run_done_cnt = 0, in_words = 0, rd_age = 100;
  bit prev_stall = 0;
  logic [127:0] prev_xy;
  logic [9:0]   prev_il;

  always begin
    bit in_fire, have_resp;
    logic [DW-1:0] resp;
    in_fire = 0; have_resp = 0; resp = '0;
    @(negedge clk);
    if (rst_n) begin
      in_fire = in_valid && in_ready;
      if (in_fire) in_words++;
      if (run_done) run_done_cnt++;
      chk("chipselect", bus.m_chipselect, bus.m_write | bus.m_read);
      if (bus.m_write || bus.m_read) begin
        chk("rd_spacing", rd_age < RDL + 1, 0);
        chk("emit_quiet", out_valid, 0);
        bus_log.push_back('{bus.m_write, bus.m_read, bus.m_addr,
                            bus.m_write ? bus.m_writedata : '0});
      end
      rd_age = bus.m_read ? 0 : (rd_age < 100 ? rd_age + 1 : rd_age);
      if (bus.m_write) begin
        case (int'(bus.m_addr[15:9]))
          8'h03: xm[bus.m_addr[8:0]] = bus.m_writedata;
          8'h04: ym[bus.m_addr[8:0]] = bus.m_writedata;
          8'h00: if (bus.m_writedata == 1) begin acked = 0; polls = 0; end
          8'h01: begin polls = 0; if (bus.m_writedata == 1) acked++; end
          default: ;
        endcase
      end
      if (bus.m_read) begin
        have_resp = 1;
        case (int'(bus.m_addr[15:9]))
          8'h40: begin
            polls++;
            resp = {$urandom, $urandom} & ~64'd1;
            resp[0] = (polls >= done_on);
          end
          8'h41: resp = xm[bus.m_addr[8:0]] + DW'(acked);
          8'h42: resp = ym[bus.m_addr[8:0]] + DW'(acked);
          default: resp = {$urandom, $urandom};
        endcase
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_xy", {out_x, out_y}, prev_xy);
        chk("hold_idx_last", {out_idx, out_last}, prev_il);
      end
      if (out_valid && out_ready) begin
        ox.push_back(out_x); oy.push_back(out_y); oil.push_back({out_idx, out_last});
      end
      prev_stall = out_valid && !out_ready;
      prev_xy = {out_x, out_y};
      prev_il = {out_idx, out_last};
    end else begin
      prev_stall = 0;
      rd_age = 100;
    end
    @(posedge clk);
    #1;
    bus.m_readdata = have_resp ? resp : {$urandom, $urandom};
    if (in_fire && src_q.size() > 0) void'(src_q.pop_front());
    in_valid = (src_q.size() > 0) && ($urandom_range(99) >= in_gap_pct);
    in_data  = (src_q.size() > 0) ? src_q[0] : '0;
    if (stall_req && out_valid && stall_cnt == 0) begin
      stall_cnt = 5;
      stall_req = 0;
    end
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else begin
      out_ready = ($urandom_range(99) < ordy_pct);
    end
  end

  task automatic do_start(input int n, input int g, input int f);
    @(posedge clk); #1;
    start = 1'b1; n_bodies = BAW'(n); gap_in = BAW'(g); n_frames = 16'(f);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_case(input string nm, input int n, input int g, input int fr,
                          input int don, input int igap, input int ordy,
                          input bit stall, input bit tmo);
    logic [DW-1:0] w[$];
    acc_t exp_bus[$];
    int cyc, nread;
    w = {};
    for (int i = 0; i < 5 * n; i++) w.push_back({$urandom, $urandom});
    src_q = w;
    bus_log.delete(); ox.delete(); oy.delete(); oil.delete();
    run_done_cnt = 0; in_words = 0;
    done_on = don; in_gap_pct = igap; ordy_pct = ordy; stall_req = stall;
    do_start(n, g, fr);
    chk({nm, "/busy_on_start"}, busy, 1);
    chk({nm, "/err_cleared"}, err, 0);
    cyc = 0;
    while (run_done_cnt == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    chk({nm, "/run_done_pulses"}, run_done_cnt, 1);
    chk({nm, "/busy_after"}, busy, 0);
    chk({nm, "/err_after"}, err, tmo);
    if (!tmo) begin
      exp_bus.push_back('{1'b1, 1'b0, ad(8'h02, 0), DW'(n)});
      exp_bus.push_back('{1'b1, 1'b0, ad(8'h08, 0), DW'(g)});
      for (int b = 0; b < n; b++)
        for (int k = 0; k < 5; k++)
          exp_bus.push_back('{1'b1, 1'b0, ad(3 + k, b), w[5 * b + k]});
      exp_bus.push_back('{1'b1, 1'b0, ad(8'h00, 0), DW'(1)});
      for (int f = 0; f < fr; f++) begin
        for (int p = 0; p < don; p++) exp_bus.push_back('{1'b0, 1'b1, ad(8'h40, 0), '0});
        for (int i = 0; i < n; i++) begin
          exp_bus.push_back('{1'b0, 1'b1, ad(8'h41, i), '0});
          exp_bus.push_back('{1'b0, 1'b1, ad(8'h42, i), '0});
        end
        exp_bus.push_back('{1'b1, 1'b0, ad(8'h01, 0), DW'(1)});
        if (f < fr - 1) exp_bus.push_back('{1'b1, 1'b0, ad(8'h01, 0), '0});
      end
      exp_bus.push_back('{1'b1, 1'b0, ad(8'h00, 0), '0});
      chk({nm, "/bus_len"}, bus_log.size(), exp_bus.size());
      for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++) begin
        chk($sformatf("%s/bus[%0d]", nm, i), bus_log[i], exp_bus[i]);
        if (bus_log[i] !== exp_bus[i]) break;
      end
      chk({nm, "/out_count"}, ox.size(), n * fr);
      for (int f = 0; f < fr; f++)
        for (int i = 0; i < n; i++)
          if (f * n + i < ox.size()) begin
            chk($sformatf("%s/out_x[%0d.%0d]", nm, f, i), ox[f * n + i], w[5 * i] + DW'(f));
            chk($sformatf("%s/out_y[%0d.%0d]", nm, f, i), oy[f * n + i], w[5 * i + 1] + DW'(f));
            chk($sformatf("%s/out_idx_last[%0d.%0d]", nm, f, i), oil[f * n + i],
                {BAW'(i), i == n - 1});
          end
    end else begin
      nread = 0;
      foreach (bus_log[i]) if (bus_log[i].w && bus_log[i].a == ad(8'h01, 0)) nread++;
      chk({nm, "/out_count"}, ox.size(), 0);
      chk({nm, "/read_writes"}, nread, 0);
      chk({nm, "/bus_nonempty"}, bus_log.size() > 0, 1);
      if (bus_log.size() > 0)
        chk({nm, "/last_is_go0"}, bus_log[bus_log.size() - 1], acc_t'({1'b1, 1'b0, ad(8'h00, 0), 64'd0}));
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst/busy", busy, 0);
    chk("rst/run_done", run_done, 0);
    chk("rst/err", err, 0);
    chk("rst/in_ready", in_ready, 0);
    chk("rst/out_valid", out_valid, 0);
    chk("rst/strobes", {bus.m_write, bus.m_read, bus.m_chipselect}, 0);
    chk("rst/addr_data", {bus.m_addr, bus.m_writedata}, 0);
    chk("rst/out_xy", {out_x, out_y}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_case("basic", 2, 0, 1, 3, 0, 100, 0, 0);
    run_case("frames3", 2, 5, 3, 2, 0, 100, 0, 0);
    for (int t = 0; t < 3; t++)
      run_case($sformatf("rand%0d", t), $urandom_range(8, 3), $urandom_range(511), 2,
               $urandom_range(4, 1), 40, 70, 1, 0);

    // rejected start: zero bodies, then zero frames
    bus_log.delete();
    do_start(0, 3, 2);
    repeat (20) @(negedge clk);
    chk("bad_start/err", err, 1);
    chk("bad_start/busy", busy, 0);
    chk("bad_start/bus_idle", bus_log.size(), 0);
    do_start(4, 3, 0);
    repeat (5) @(negedge clk);
    chk("bad_frames/err", err, 1);
    chk("bad_frames/busy", busy, 0);
    run_case("after_err", 1, 7, 1, 1, 0, 100, 0, 0);

    // asynchronous reset in the middle of LOAD
    src_q.delete();
    for (int i = 0; i < 10; i++) src_q.push_back({$urandom, $urandom});
    in_words = 0; in_gap_pct = 30; done_on = 1;
    do_start(2, 1, 1);
    cyc = 0;
    while (in_words < 7 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reset/words_reached", in_words >= 7, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset/strobes", {bus.m_write, bus.m_read, bus.m_chipselect}, 0);
    chk("mid_reset/busy_ready", {busy, in_ready, out_valid}, 0);
    repeat (3) @(negedge clk);
    src_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_case("rerun", 2, 0, 1, 3, 20, 100, 0, 0);

`ifdef NBODY_DRV_TIMEOUT_EN
    run_case("timeout", 1, 0, 1, 1 << 30, 0, 100, 0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
